// File: rtl/riscv_debug_overlay_if.sv
// Video-side bundle of the debug overlay: pixel coordinates and vsync in, character ROM address and highlight out.
interface riscv_debug_overlay_if;
    logic [9:0] pixelRow;
    logic [9:0] pixelColumn;
    logic       vert_sync;
    logic [5:0] characterAddress;
    logic       highlight;

    modport master (
        output pixelRow, pixelColumn, vert_sync,
        input  characterAddress, highlight
    );

    modport slave (
        input  pixelRow, pixelColumn, vert_sync,
        output characterAddress, highlight
    );
endinterface

// File: rtl/riscv_debug_overlay.sv
// Labelled hex register overlay on a 40x30 character grid with per-frame snapshots and change highlighting.
// Optional frame counter on row 28 is built when RISCV_OVERLAY_FRAME_COUNTER_EN is defined.
module riscv_debug_overlay #(
    parameter int NUM_REGS         = 4,
    parameter int DATA_W           = 32,
    parameter int FIRST_ROW        = 4,
    parameter int ROW_STEP         = 2,
    parameter int VALUE_COL        = 11,
    parameter int HIGHLIGHT_FRAMES = 30
) (
    input  logic                         clock,
    input  logic                         reset,
    riscv_debug_overlay_if.slave         vga,
    input  logic                         freeze,
    input  logic [NUM_REGS*DATA_W-1:0]   values_in,
    input  logic [NUM_REGS*24-1:0]       labels_in
);
    localparam int ND = DATA_W / 4;
    localparam logic [7:0] HL_INIT = 8'(HIGHLIGHT_FRAMES);

    if (NUM_REGS < 1 || NUM_REGS > 8) begin : g_bad_num_regs
        $error("NUM_REGS out of range");
    end
    if (DATA_W < 4 || DATA_W > 32 || (DATA_W % 4) != 0) begin : g_bad_data_w
        $error("DATA_W must be a multiple of 4 in 4..32");
    end
    if (ROW_STEP < 1 || ROW_STEP > 4 || FIRST_ROW + (NUM_REGS - 1) * ROW_STEP > 29) begin : g_bad_rows
        $error("field rows do not fit the grid");
    end
    if (VALUE_COL + ND - 1 > 39 || HIGHLIGHT_FRAMES < 0 || HIGHLIGHT_FRAMES > 255) begin : g_bad_cols
        $error("value columns or highlight length out of range");
    end

    logic                vs_d_r;
    logic                frame_tick_s;
    logic [DATA_W-1:0]   shadow_r [NUM_REGS];
    logic [7:0]          hl_cnt_r [NUM_REGS];
    logic [4:0]          row_s;
    logic [5:0]          col_s;
    logic                fld_hit_s;
    logic [DATA_W-1:0]   cur_val_s;
    logic [23:0]         lbl_word_s;
    logic                cur_hl_s;
    logic                lbl_col_s;
    logic                val_col_s;
    logic [1:0]          lbl_sel_s;
    logic [5:0]          digit_s;
    logic [5:0]          shamt_s;
    logic [3:0]          nib_s;
    logic [5:0]          char_s;
    logic                hl_s;
    logic [5:0]          char_r;
    logic                hl_r;
    logic                unused_s;

    assign row_s        = vga.pixelRow[8:4];
    assign col_s        = vga.pixelColumn[9:4];
    assign unused_s     = ^{vga.pixelRow[9], vga.pixelRow[3:0], vga.pixelColumn[3:0]};
    assign frame_tick_s = vs_d_r & ~vga.vert_sync;
    assign lbl_col_s    = (col_s >= 6'd5) && (col_s <= 6'd8);
    assign lbl_sel_s    = 2'(col_s - 6'd5);
    assign val_col_s    = (col_s >= 6'(VALUE_COL)) && (col_s < 6'(VALUE_COL + ND));
    assign digit_s      = col_s - 6'(VALUE_COL);
    assign shamt_s      = 6'(ND - 1) - digit_s;
    assign nib_s        = 4'(cur_val_s >> {shamt_s, 2'b00});

`ifdef RISCV_OVERLAY_FRAME_COUNTER_EN
    logic [15:0] frame_cnt_r;
    logic [3:0]  cnt_nib_s;
    logic        cnt_col_s;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_row28_check
        if (FIRST_ROW + g * ROW_STEP == 28) begin : g_bad
            $error("field row collides with the frame counter row");
        end
    end
    if (VALUE_COL + 3 > 39) begin : g_bad_cnt_cols
        $error("frame counter digits do not fit the row");
    end

    assign cnt_nib_s = 4'(frame_cnt_r >> {6'd3 - digit_s, 2'b00});
    assign cnt_col_s = (col_s >= 6'(VALUE_COL)) && (col_s < 6'(VALUE_COL + 4));

    // Free-running frame counter; keeps counting while the display is frozen.
    always_ff @(posedge clock) begin
        if (reset) begin
            frame_cnt_r <= 16'd0;
        end else if (frame_tick_s) begin
            frame_cnt_r <= frame_cnt_r + 16'd1;
        end else begin
            frame_cnt_r <= frame_cnt_r;
        end
    end
`endif

    // Vsync edge detector plus per-field snapshot and highlight countdown.
    always_ff @(posedge clock) begin
        if (reset) begin
            vs_d_r <= 1'b1;
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow_r[i] <= {DATA_W{1'b0}};
                hl_cnt_r[i] <= 8'd0;
            end
        end else begin
            vs_d_r <= vga.vert_sync;
            if (frame_tick_s) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (!freeze && (values_in[i*DATA_W +: DATA_W] != shadow_r[i])) begin
                        shadow_r[i] <= values_in[i*DATA_W +: DATA_W];
                        hl_cnt_r[i] <= HL_INIT;
                    end else if (hl_cnt_r[i] != 8'd0) begin
                        hl_cnt_r[i] <= hl_cnt_r[i] - 8'd1;
                    end else begin
                        hl_cnt_r[i] <= 8'd0;
                    end
                end
            end
        end
    end

    // Cell decode: pick the field on this row, then label, hex digit or blank.
    always_comb begin
        fld_hit_s  = 1'b0;
        cur_val_s  = {DATA_W{1'b0}};
        lbl_word_s = 24'd0;
        cur_hl_s   = 1'b0;
        char_s     = 6'o40;
        hl_s       = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (row_s == 5'(FIRST_ROW + i * ROW_STEP)) begin
                fld_hit_s  = 1'b1;
                cur_val_s  = shadow_r[i];
                lbl_word_s = labels_in[i*24 +: 24];
                cur_hl_s   = (hl_cnt_r[i] != 8'd0);
            end else begin
                fld_hit_s  = fld_hit_s;
            end
        end
        if (fld_hit_s) begin
            if (lbl_col_s) begin
                case (lbl_sel_s)
                    2'd0:    char_s = lbl_word_s[23:18];
                    2'd1:    char_s = lbl_word_s[17:12];
                    2'd2:    char_s = lbl_word_s[11:6];
                    2'd3:    char_s = lbl_word_s[5:0];
                    default: char_s = 6'o40;
                endcase
            end else if (val_col_s) begin
                char_s = {2'b11, nib_s};
                hl_s   = cur_hl_s;
            end else begin
                char_s = 6'o40;
            end
`ifdef RISCV_OVERLAY_FRAME_COUNTER_EN
        end else if (row_s == 5'd28) begin
            if (lbl_col_s) begin
                case (lbl_sel_s)
                    2'd0:    char_s = 6'o06;
                    2'd1:    char_s = 6'o22;
                    2'd2:    char_s = 6'o15;
                    default: char_s = 6'o40;
                endcase
            end else if (cnt_col_s) begin
                char_s = {2'b11, cnt_nib_s};
            end else begin
                char_s = 6'o40;
            end
`endif
        end else begin
            char_s = 6'o40;
        end
    end

    // One-cycle registered output stage toward the character ROM.
    always_ff @(posedge clock) begin
        if (reset) begin
            char_r <= 6'o40;
            hl_r   <= 1'b0;
        end else begin
            char_r <= char_s;
            hl_r   <= hl_s;
        end
    end

    assign vga.characterAddress = char_r;
    assign vga.highlight        = hl_r;
endmodule

// File: doc/riscv_debug_overlay.md
Name: riscv_debug_overlay

Overview:
- Parametrised successor to the single-screen PC/INST text generator. Displays NUM_REGS labelled hex fields on the 40x30 VGA character grid (16x16-pixel cells).
- Values are snapshotted once per frame, so a field never tears mid-frame.
- Fields whose value changed are highlighted for a programmable number of frames.
- Sits between the RISC-V core debug taps and the character ROM / VGA sync path.
- Output is registered; the character ROM consumer accounts for the 1-cycle latency.

Parameters:
- NUM_REGS, 4: number of displayed fields; 1..8.
- DATA_W, 32: bits per field; multiple of 4, 4..32. Hex digits per field ND = DATA_W/4.
- FIRST_ROW, 4: character row of field 0.
- ROW_STEP, 2: character-row pitch between fields; 1..4. Elaboration check: FIRST_ROW+(NUM_REGS-1)*ROW_STEP <= 29.
- VALUE_COL, 11: column of the first (most significant) hex digit. Elaboration check: VALUE_COL+ND-1 <= 39.
- HIGHLIGHT_FRAMES, 30: frames a changed field stays highlighted; 0..255; 0 disables highlighting.

Ports:
- clock, in, 1: pixel clock.
- reset, in, 1: synchronous, active-high.
- pixelRow, in, 10: current pixel row from the sync generator.
- pixelColumn, in, 10: current pixel column.
- vert_sync, in, 1: active-low vertical sync.
- freeze, in, 1: when high, snapshots are suppressed and the display holds.
- values_in, in, NUM_REGS*DATA_W: live values; field i is bits [i*DATA_W +: DATA_W].
- labels_in, in, NUM_REGS*24: four 6-bit character codes per field; field i is bits [i*24 +: 24], code for column 5 in the MSBs.
- characterAddress, out, 6: character ROM address, registered.
- highlight, out, 1: invert-video request for the current cell, registered and aligned with characterAddress.

Behaviour:
- Cell decode: row_address = pixelRow[8:4], col_address = pixelColumn[9:4].
- Field i occupies row FIRST_ROW+i*ROW_STEP.
  - Columns 5..8: the four label codes from labels_in.
  - Columns VALUE_COL..VALUE_COL+ND-1: {2'b11, nibble} of shadow[i], MSB nibble first.
  - All other cells: space, 6'o40.
- Latency: characterAddress and highlight reflect the pixelRow/pixelColumn sampled on the previous clock edge. Exactly 1 cycle, no bubbles.
- Frame edge: vs_d registers vert_sync. frame_tick = vs_d & ~vert_sync, i.e. a one-cycle pulse on the falling edge of vert_sync.
- On frame_tick with freeze=0, for every i:
  - shadow[i] <= values_in field i.
  - If the new value differs from shadow[i], hl_cnt[i] <= HIGHLIGHT_FRAMES.
  - Otherwise hl_cnt[i] decrements, saturating at 0.
- On frame_tick with freeze=1: shadow is held and no reload happens. hl_cnt still decrements, so highlights fade while frozen.
- A change detected while hl_cnt is nonzero reloads the counter to full.
- highlight = 1 only on value-digit cells of field i with hl_cnt[i] != 0. Label and blank cells are never highlighted.
- values_in changing between frame ticks has no visible effect until the next unfrozen tick.
- Reset:
  - characterAddress = 6'o40, highlight = 0.
  - vs_d = 1, so there is no spurious tick on the first cycle.
  - Every shadow = 0 and every hl_cnt = 0.
  - The frame counter (optional feature) = 0.
- Reset has priority over frame_tick in the same cycle.
- The first post-reset snapshot of a nonzero value counts as a change.

Optional Feature:
- Macro: RISCV_OVERLAY_FRAME_COUNTER_EN.
- When defined:
  - A 16-bit frame_cnt increments on every frame_tick, regardless of freeze, and wraps 16'hFFFF -> 0.
  - Row 28 shows: column 5 'F' (6'o06), column 6 'R' (6'o22), column 7 'M' (6'o15), column 8 space, then columns VALUE_COL..VALUE_COL+3 show the 4 hex digits of frame_cnt.
  - This row is never highlighted.
  - Elaboration fails if any field row equals 28.
- When undefined: no counter is built and row 28 behaves like any other unused row (spaces).

Test Plan:
- Reset, then scan row 4 column 11 -> characterAddress=6'o60 one cycle after the pixel coordinates are applied; highlight=0.
- Defaults; values_in field0=32'h1234ABCD; one vert_sync falling edge -> row 4 columns 11..18 read 6'o61,62,63,64,72,73,74,75 and highlight=1 on those cells.
- Hold field0 constant for 30 more frame ticks -> highlight stays 1 through tick 29 after the load and reads 0 after tick 30. Change one bit -> highlight=1 again on the next tick.
- freeze=1; change field1 to 32'hFFFFFFFF; 3 frame ticks -> row 6 still shows the old value with no new highlight. Deassert freeze; next tick -> row 6 shows all 6'o77 with highlight=1.
- reset asserted in the same cycle as a frame_tick with a changed value -> shadow=0, hl_cnt=0, characterAddress=6'o40 next cycle.
- With RISCV_OVERLAY_FRAME_COUNTER_EN defined, after 65537 frame ticks -> row 28 columns 11..14 read 0,0,0,1 (6'o60,60,60,61).
